// File: rtl/uart_pkg.sv
// uart_pkg: line levels, frame size and FSM states
// shared by the UART transmit arbiter files.
package uart_pkg;

  localparam int   FRAME_BITS = 10;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam logic IDLE_LVL   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: valid/ready byte bundle from
// NUM_REQ producers into the UART arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 shifter with baud divider
// and a mandatory idle-high gap after each stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int GAP_W  = $clog2(GAP_BITS * CLKS_PER_BIT + 1);
  localparam int SH_W   = FRAME_BITS - 1;

  localparam logic [BAUD_W-1:0] BAUD_TOP =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_TOP =
    GAP_W'(GAP_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [3:0]        bit_q, bit_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // The start bit goes straight to the line on load, so the
  // shifter only holds the data byte and the stop bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sh_d    = {STOP_LVL, data};
          tx_d    = START_LVL;
          busy_d  = 1'b1;
          baud_d  = BAUD_TOP;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d = BAUD_TOP;
          if (bit_q != LAST_BIT) begin
            tx_d  = sh_q[0];
            sh_d  = {IDLE_LVL, sh_q[SH_W-1:1]};
            bit_d = bit_q + 4'd1;
          end else begin
            tx_d    = IDLE_LVL;
            done_d  = 1'b1;
            gap_d   = GAP_TOP;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        tx_d = IDLE_LVL;
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX
// line among NUM_REQ byte producers.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 1,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave req,
  output logic             uart_tx,
  output logic             busy,
  output logic [ID_W-1:0]  grant_id,
  output logic             frame_done
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               accept;
  logic [NUM_REQ-1:0] ready;
  logic [7:0]         win_data;

  // Scan downward so the nearest valid requester after
  // the pointer is the last one written.
  always_comb begin
    int idx;
    idx   = 0;
    win   = ptr_q;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req.req_valid[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign accept   = found & ~busy;
  assign win_data = req.req_data[8*int'(win) +: 8];

  always_comb begin
    ready = '0;
    if (accept) ready[win] = 1'b1;
  end

  assign req.req_ready = ready;

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    if (accept) begin
      grant_d = win;
      ptr_d   = (int'(win) == NUM_REQ - 1) ? '0
                                           : win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant_id = grant_q;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .data  (win_data),
    .busy  (busy),
    .done  (frame_done),
    .tx    (uart_tx)
  );

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit line among NUM_REQ byte producers, e.g. the CPU store-to-UART path and debug/trace sources. Round-robin arbitration grants one requester per frame. The granted byte is serialized as 8N1 (start 0, 8 data bits LSB first, stop 1), followed by a mandatory idle gap. The gap lets the bench-side UART monitor, which discards the sample taken in the cycle it completes a frame, capture every frame.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
CLKS_PER_BIT, 1, clk cycles per UART bit (legal >=1; 1 matches the bench monitor)
GAP_BITS, 1, idle-high bit periods enforced after each stop bit (legal >=1)
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester byte valid; once raised, held with stable data until ready
req_data  in  NUM_REQ*8  byte of requester i at [8*i+7:8*i]
req_ready  out  NUM_REQ  one-hot accept; transfer occurs when valid&ready at a clk edge
uart_tx  out  1  serial line, registered, idles high
busy  out  1  high from the accept edge until return to IDLE
grant_id  out  ID_W  index of the last-granted requester, registered
frame_done  out  1  one-cycle pulse on the edge where the stop bit period ends

Behaviour:
- Reset values: uart_tx=1, req_ready=0, busy=0, grant_id=0, frame_done=0, RR pointer=0 (requester 0 first), state=IDLE.
- Reset is asynchronous. Asserting it mid-frame forces uart_tx=1 immediately and aborts the frame; the aborted byte is not retried.
- FSM states:
  - IDLE: req_ready is combinational: one-hot of the RR winner, only in IDLE.
  - RR search starts at (last grant+1) mod NUM_REQ, or at 0 after reset.
  - If no req_valid is high, stay in IDLE with req_ready=0.
  - On the accept edge: latch frame={1,data,0}, set grant_id, busy=1, uart_tx=0 (start bit), load baud counter CLKS_PER_BIT-1, bit_cnt=0, go to SHIFT.
  - SHIFT: baud counter decrements each cycle. At 0, reload it; if bit_cnt<9, shift the next frame bit onto uart_tx and increment bit_cnt.
  - SHIFT, bit_cnt==9 at baud 0: drive uart_tx=1, pulse frame_done, load gap counter GAP_BITS*CLKS_PER_BIT-1, go to GAP.
  - GAP: uart_tx=1, busy=1. When the gap counter reaches 0, go to IDLE and set busy=0.
- Each bit is held exactly CLKS_PER_BIT cycles.
- Back-to-back start-bit spacing is (10+GAP_BITS)*CLKS_PER_BIT+1 cycles. IDLE always costs one cycle.
- req_valid changes outside IDLE are ignored. Requesters not granted keep waiting; they are never dropped.
- Fairness: with all requesters continuously valid, the grant order is 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 frames.
- A single requester continuously valid is granted every frame; the pointer wraps back to it.
- Width rules: baud counter is $clog2(CLKS_PER_BIT+1) bits; gap counter is $clog2(GAP_BITS*CLKS_PER_BIT+1) bits; bit_cnt is 4 bits.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME_BITS=10, START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1
  - state typedef {IDLE, SHIFT, GAP}
- Natural sub-module uart_tx_serializer: baud counter, 10-bit shifter, gap counter, with ports load/data/busy/done.
- The top level holds the RR arbiter, req_ready decode and grant_id.

Test Plan:
- Reset, then no valid for 50 cycles -> uart_tx=1, busy=0, req_ready=0, frame_done never pulses.
- CPB=1, GAP=1; req0 valid with 0x41 -> req_ready[0] high 1 cycle; uart_tx sequence 0,1,0,0,0,0,0,1,0,1; frame_done on the 10th edge; bench monitor prints "A".
- All 4 valid with 0x30..0x33, each held until accepted -> grants 0,1,2,3; start bits spaced 12 cycles apart; monitor prints "0123".
- req2 continuously valid (0x55) with req1 raised during frame 1 -> next grant is 1, then 2; req1 byte not lost.
- CPB=4, GAP=2; send 0xA5 -> each bit held 4 cycles; line high 9 cycles between stop bit end and next start bit.
- Assert rst_n low during data bit 3, release 5 cycles later with req1 valid -> uart_tx=1 immediately on reset; first grant after reset is req1 (pointer=0, req0 idle); a clean frame follows.
